conv3x3_engine: RTL
===================

CONV3X3_ENGINE -- requirements
Module: conv3x3_engine

Interface
REQ-001 SHALL have parameter H, default 28, meaning image height in pixels.
REQ-002 SHALL have parameter W, default 28, meaning image width in pixels.
REQ-003 SHALL have parameter SHIFT, default 7, meaning right-shift applied to the accumulator before saturation.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  begin one full-image sweep; sampled in IDLE only.
REQ-007 SHALL have port w_we  input  1  kernel weight write strobe.
REQ-008 SHALL have port w_addr  input  4  weight index 0..8, row-major.
REQ-009 SHALL have port w_data  input  8  signed weight value.
REQ-010 SHALL have port bias  input  16  signed bias; held static during a sweep.
REQ-011 SHALL have port i  output  5  patch row sent to the upstream patch stage.
REQ-012 SHALL have port j  output  5  patch column sent to the upstream patch stage.
REQ-013 SHALL have port load  output  1  patch request, one-cycle pulse.
REQ-014 SHALL have port pixels_flat  input  72  patch pixels, unsigned; pixel k at bits [8k+7:8k], k row-major 0..8.
REQ-015 SHALL have port pix_valid  input  1  pixels_flat is valid for the current i,j.
REQ-016 SHALL have port out_data  output  8  ReLU'd, shifted, saturated result.
REQ-017 SHALL have port out_addr  output  10  output index i*(W-2)+j.
REQ-018 SHALL have port out_valid  output  1  out_data/out_addr valid, one-cycle pulse.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse at sweep end.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, WAIT, MAC, OUT, NEXT, DONE.
REQ-022 SHALL go IDLE->LOAD on start=1 with i=0, j=0.
REQ-023 SHALL assert load=1 only in LOAD, for exactly one cycle, then go to WAIT.
REQ-024 SHALL sample pix_valid only in WAIT; a pix_valid in any other state is ignored; WAIT has no timeout.
REQ-025 SHALL capture pixels_flat into an internal register on the WAIT cycle with pix_valid=1, clear the accumulator to bias sign-extended to 22 bits, and enter MAC.
REQ-026 SHALL spend exactly 9 cycles in MAC, adding one product pixel[k]*weight[k] per cycle for k=0..8; the tap counter runs 0..8 and then goes to OUT.
REQ-027 SHALL treat each product as unsigned 8 x signed 8, giving 17-bit signed; SHALL hold the accumulator at 22-bit signed with no overflow possible.
REQ-028 SHALL in OUT assert out_valid for one cycle with out_data = 0 if acc<0, else min(acc>>>SHIFT, 255), and out_addr = i*(W-2)+j.
REQ-029 SHALL produce out_valid exactly 10 cycles after the accepted pix_valid cycle.
REQ-030 SHALL in NEXT advance j; if j=W-3, set j=0 and advance i; if i=H-3 and j=W-3, go to DONE, else go to LOAD.
REQ-031 SHALL pulse done for one cycle in DONE, then return to IDLE; IDLE follows DONE by one cycle.
REQ-032 SHALL ignore start while busy=1.
REQ-033 SHALL accept w_we only in IDLE and ignore it while busy; w_addr>8 is ignored.
REQ-034 SHALL produce exactly (H-2)*(W-2) out_valid pulses per sweep, i.e. 676 at the defaults.

Reset
REQ-035 SHALL on rst=1 at a clock edge enter IDLE and clear all 9 weights, the accumulator, the tap counter, the pixel register, i, j, load, out_data, out_addr, out_valid, busy and done to 0.
REQ-036 SHALL abort any sweep in progress on rst=1 (mid-MAC included) without emitting out_valid or done.

Structure
REQ-037 SHALL take the FSM state enum, the accumulator width (22), the product width (17) and the tap count (9) from shared package conv_pkg.
REQ-038 SHALL place the ReLU/shift/saturate step in combinational sub-module relu_sat.

Verification
REQ-039 SHALL cover: weights all 1, bias 0, SHIFT=0, all pixels 10 -> out_data=90, out_valid 10 cycles after pix_valid.
REQ-040 SHALL cover: weights all -1, pixels 5, bias 0 -> out_data=0 (ReLU).
REQ-041 SHALL cover: weights all 127, pixels 255, SHIFT=0 -> out_data=255 (saturation); the same case with SHIFT=7 -> 255; a case with weights 1, pixels 14, bias 2, SHIFT=7 -> out_data=1.
REQ-042 SHALL cover: a full sweep with pix_valid returned 2 cycles after each load -> 676 out_valid pulses, out_addr 0..675 in order, last at i=25 j=25, done exactly one cycle after the OUT cycle of the final output plus the NEXT cycle.
REQ-043 SHALL cover: rst asserted at MAC tap 4 -> next cycle busy=0, out_valid=0, weights=0; a subsequent start restarts at i=0, j=0.
REQ-044 SHALL cover: start and w_we pulsed during WAIT -> no restart, weights unchanged, sweep results unaffected.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution engine.
// Holds the sweep FSM state type, the datapath widths and the per-tap
// product helper used by the MAC stage.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWait,
    StMac,
    StOut,
    StNext,
    StDone
  } state_e;

  localparam int unsigned AccW    = 22;
  localparam int unsigned ProdW   = 17;
  localparam int unsigned NumTaps = 9;
  localparam int unsigned TapW    = 4;

  // Unsigned pixel times signed weight. Both operands are widened to the
  // product width first so the multiply is a plain signed one.
  function automatic logic signed [ProdW-1:0] tap_product(input logic [7:0]        pix,
                                                          input logic signed [7:0] w);
    logic signed [ProdW-1:0] pix_ext;
    logic signed [ProdW-1:0] w_ext;
    pix_ext = {9'b0, pix};
    w_ext   = {{9{w[7]}}, w};
    return pix_ext * w_ext;
  endfunction

endpackage

// File: rtl/relu_sat.sv
// ReLU, arithmetic right shift and saturation to 8 bits.
// Ports:
//   acc_i : signed accumulator value
//   res_o : 0 if acc_i < 0, else min(acc_i >>> SHIFT, 255)
module relu_sat
  import conv_pkg::*;
#(
  parameter int unsigned SHIFT = 7
) (
  input  logic signed [AccW-1:0] acc_i,
  output logic        [7:0]      res_o
);

  logic [AccW-1:0] shifted;

  always_comb begin
    // Logical shift is fine here: the value is only used when non-negative.
    shifted = acc_i >> SHIFT;
    if (acc_i[AccW-1]) begin
      res_o = 8'h00;
    end else if (|shifted[AccW-1:8]) begin
      res_o = 8'hFF;
    end else begin
      res_o = shifted[7:0];
    end
  end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 convolution engine sweeping an H x W image with a programmable kernel.
// For every valid output position it requests a patch (load + i/j), waits for
// pix_valid, accumulates 9 products one per cycle, then emits one result.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a sweep (IDLE only)
//   w_we, w_addr, w_data  : kernel weight write port (IDLE only)
//   bias                  : signed bias added to every output
//   i, j, load            : patch request to the upstream patch stage
//   pixels_flat, pix_valid: patch returned by the upstream stage
//   out_data/addr/valid   : result stream
//   busy, done            : sweep status
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int unsigned H     = 28,
  parameter int unsigned W     = 28,
  parameter int unsigned SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        w_we,
  input  logic [3:0]  w_addr,
  input  logic [7:0]  w_data,
  input  logic [15:0] bias,
  output logic [4:0]  i,
  output logic [4:0]  j,
  output logic        load,
  input  logic [71:0] pixels_flat,
  input  logic        pix_valid,
  output logic [7:0]  out_data,
  output logic [9:0]  out_addr,
  output logic        out_valid,
  output logic        busy,
  output logic        done
);

  state_e                 state_q, state_d;
  logic [4:0]             i_q, i_d;
  logic [4:0]             j_q, j_d;
  logic [TapW-1:0]        tap_q, tap_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [71:0]            pix_q, pix_d;
  logic signed [7:0]      w_q [NumTaps];
  logic signed [7:0]      w_d [NumTaps];

  logic [7:0]              pix_tap;
  logic signed [7:0]       w_tap;
  logic signed [ProdW-1:0] prod;

  // Select the pixel/weight pair for the current tap.
  always_comb begin
    pix_tap = 8'h00;
    w_tap   = '0;
    for (int k = 0; k < NumTaps; k++) begin
      if (tap_q == TapW'(k)) begin
        pix_tap = pix_q[8*k +: 8];
        w_tap   = w_q[k];
      end
    end
    prod = tap_product(pix_tap, w_tap);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    pix_d   = pix_q;
    w_d     = w_q;

    case (state_q)
      StIdle: begin
        if (w_we && (w_addr < 4'(NumTaps))) begin
          w_d[w_addr] = w_data;
        end
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          state_d = StLoad;
        end
      end
      StLoad: state_d = StWait;
      StWait: begin
        if (pix_valid) begin
          pix_d   = pixels_flat;
          acc_d   = AccW'($signed(bias));
          tap_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + AccW'(prod);
        if (tap_q == TapW'(NumTaps - 1)) begin
          tap_d   = '0;
          state_d = StOut;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      StOut: state_d = StNext;
      StNext: begin
        if (j_q == 5'(W - 3)) begin
          if (i_q == 5'(H - 3)) begin
            state_d = StDone;
          end else begin
            j_d     = '0;
            i_d     = i_q + 5'd1;
            state_d = StLoad;
          end
        end else begin
          j_d     = j_q + 5'd1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      pix_q   <= '0;
      for (int k = 0; k < NumTaps; k++) begin
        w_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      pix_q   <= pix_d;
      w_q     <= w_d;
    end
  end

  relu_sat #(
    .SHIFT(SHIFT)
  ) u_relu_sat (
    .acc_i(acc_q),
    .res_o(out_data)
  );

  assign i         = i_q;
  assign j         = j_q;
  assign load      = (state_q == StLoad);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_addr  = 10'(i_q) * 10'(W - 2) + 10'(j_q);

endmodule
